// File: rtl/match_pkg.sv
// Shared match definitions: phase and winner encodings plus default match
// parameters. The game-screen state machine imports this package too, so the
// encodings must stay in step with what it decodes.
package match_pkg;

  typedef enum logic [1:0] {
    PH_SPLASH = 2'd0,
    PH_SERVE  = 2'd1,
    PH_PLAY   = 2'd2,
    PH_OVER   = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_e;

  localparam int unsigned WIN_SCORE_DEF   = 5;   // points that end the match (1..7)
  localparam int unsigned SERVE_TICKS_DEF = 60;  // frames of pre-serve pause (1..255)

endpackage

// File: rtl/match_controller_if.sv
// Match controller signal bundle. The game side (master) drives the frame
// strobe, start button and goal strobes; the controller (slave) returns the
// match phase, scores and ball control.
interface match_controller_if;

  logic       tick;
  logic       start;
  logic       goal_p1;
  logic       goal_p2;
  logic [1:0] phase;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [1:0] winner;
  logic       play_en;
  logic       ball_reset;
  logic       serve_dir;

  modport master (
    output tick, start, goal_p1, goal_p2,
    input  phase, p1_score, p2_score, winner, play_en, ball_reset, serve_dir
  );

  modport slave (
    input  tick, start, goal_p1, goal_p2,
    output phase, p1_score, p2_score, winner, play_en, ball_reset, serve_dir
  );

endinterface

// File: rtl/serve_timer.sv
// Pre-serve countdown: 8-bit down-counter loaded at the start of each serve and
// decremented on frame ticks. done_o flags that the count is zero after this
// edge, so the FSM can leave SERVE on the same edge the count reaches zero.
module serve_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic       done_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: load wins, otherwise count down on tick and stop at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  assign done_o = (count_d == 8'd0);

  // Count register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering; blocking here would race.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Match controller: sequences SPLASH -> SERVE -> PLAY -> (SERVE | OVER), keeps
// score, and drives ball-control signals. All outputs come from registers, so
// every response shows up the cycle after the input that caused it.
module match_controller
  import match_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned SERVE_TICKS = SERVE_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  match_controller_if.slave  bus
);

  localparam logic [2:0] WIN_PTS    = 3'(WIN_SCORE);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS);

  phase_e     state_q, state_d;
  logic       start_prev_q;
  logic [2:0] p1_q, p1_d;
  logic [2:0] p2_q, p2_d;
  winner_e    winner_q, winner_d;
  logic       play_en_q;
  logic       ball_reset_q, ball_reset_d;
  logic       serve_dir_q, serve_dir_d;

  logic       start_rise;
  logic       goal1, goal2;
  logic       p1_wins, p2_wins;
  logic       timer_load, timer_tick, timer_done;

  // Simultaneous goals credit player 1 only.
  assign start_rise = bus.start & ~start_prev_q;
  assign goal1      = bus.goal_p1;
  assign goal2      = bus.goal_p2 & ~bus.goal_p1;
  assign p1_wins    = ((p1_q + 3'd1) == WIN_PTS);
  assign p2_wins    = ((p2_q + 3'd1) == WIN_PTS);
  assign timer_tick = bus.tick & (state_q == PH_SERVE);

  serve_timer u_serve_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (SERVE_LOAD),
    .tick_i     (timer_tick),
    .done_o     (timer_done)
  );

  // State register and start-button history (history resets high so a start
  // held through reset does not count as a press).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PH_SPLASH;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus.start;
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PH_SPLASH: if (start_rise) state_d = PH_SERVE;
      PH_SERVE:  if (timer_done) state_d = PH_PLAY;
      PH_PLAY: begin
        if (goal1)      state_d = p1_wins ? PH_OVER : PH_SERVE;
        else if (goal2) state_d = p2_wins ? PH_OVER : PH_SERVE;
      end
      PH_OVER:   if (start_rise) state_d = PH_SPLASH;
      default:   state_d = PH_SPLASH;
    endcase
  end

  // Output next-values: scores, winner, serve direction, ball reset, timer load.
  always_comb begin
    p1_d         = p1_q;
    p2_d         = p2_q;
    winner_d     = winner_q;
    serve_dir_d  = serve_dir_q;
    ball_reset_d = 1'b0;
    timer_load   = 1'b0;
    unique case (state_q)
      PH_SPLASH: begin
        if (start_rise) begin
          p1_d         = 3'd0;
          p2_d         = 3'd0;
          winner_d     = WIN_NONE;
          serve_dir_d  = 1'b0;
          timer_load   = 1'b1;
          ball_reset_d = 1'b1;
        end
      end
      PH_PLAY: begin
        if (goal1) begin
          p1_d = p1_q + 3'd1;
          if (p1_wins) begin
            winner_d = WIN_P1;
          end else begin
            timer_load   = 1'b1;
            ball_reset_d = 1'b1;
            serve_dir_d  = 1'b1;
          end
        end else if (goal2) begin
          p2_d = p2_q + 3'd1;
          if (p2_wins) begin
            winner_d = WIN_P2;
          end else begin
            timer_load   = 1'b1;
            ball_reset_d = 1'b1;
            serve_dir_d  = 1'b0;
          end
        end
      end
      PH_OVER: begin
        if (start_rise) begin
          p1_d     = 3'd0;
          p2_d     = 3'd0;
          winner_d = WIN_NONE;
        end
      end
      default: ;
    endcase
  end

  // Output registers; play_en tracks the next state so it drops on the same
  // edge the phase leaves PLAY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_q         <= 3'd0;
      p2_q         <= 3'd0;
      winner_q     <= WIN_NONE;
      play_en_q    <= 1'b0;
      ball_reset_q <= 1'b0;
      serve_dir_q  <= 1'b0;
    end else begin
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      winner_q     <= winner_d;
      play_en_q    <= (state_d == PH_PLAY);
      ball_reset_q <= ball_reset_d;
      serve_dir_q  <= serve_dir_d;
    end
  end

  assign bus.phase      = state_q;
  assign bus.p1_score   = p1_q;
  assign bus.p2_score   = p2_q;
  assign bus.winner     = winner_q;
  assign bus.play_en    = play_en_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.serve_dir  = serve_dir_q;

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter WIN_SCORE, default 5, points that end the match; legal range 1..7.
REQ-002 Parameter SERVE_TICKS, default 60, tick count of the pre-serve pause; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 tick  input  1  one-cycle frame-rate enable strobe.
REQ-006 start  input  1  debounced start button level; the block edge-detects it internally.
REQ-007 goal_p1  input  1  one-cycle strobe: player 1 scored.
REQ-008 goal_p2  input  1  one-cycle strobe: player 2 scored.
REQ-009 phase  output  2  match phase: 0 SPLASH, 1 SERVE, 2 PLAY, 3 OVER.
REQ-010 p1_score, p2_score  output  3 each  current points.
REQ-011 winner  output  2  0 none, 1 player 1, 2 player 2.
REQ-012 play_en  output  1  high only in PLAY; ball motion permitted.
REQ-013 ball_reset  output  1  one-cycle pulse to recentre ball and paddles.
REQ-014 serve_dir  output  1  0 serve toward player 1, 1 toward player 2.

Function
REQ-015 All outputs SHALL be registered; all responses appear the cycle after the causing input is sampled.
REQ-016 start_rise SHALL be start high while its previous-cycle sample is low; a held start SHALL produce exactly one rise.
REQ-017 SPLASH: on start_rise -> SERVE; scores cleared; winner 0; serve_dir 0; countdown loaded with SERVE_TICKS; ball_reset pulsed.
REQ-018 SERVE: countdown SHALL decrement by one on each cycle with tick high; when countdown equals 0 the next state SHALL be PLAY.
REQ-019 PLAY: play_en high; goal_p1 increments p1_score, goal_p2 increments p2_score.
REQ-020 Simultaneous goal_p1 and goal_p2 SHALL credit player 1 only; goal_p2 is discarded.
REQ-021 A goal making a score equal WIN_SCORE -> OVER, winner set to scorer, no ball_reset.
REQ-022 Any other goal -> SERVE, countdown reloaded with SERVE_TICKS, ball_reset pulsed, serve_dir set toward the conceding player (1 after a player-1 point, 0 after a player-2 point).
REQ-023 OVER: scores and winner held; on start_rise -> SPLASH with scores and winner cleared.
REQ-024 Goal strobes outside PLAY, start_rise in SERVE or PLAY, and tick outside SERVE SHALL be ignored.
REQ-025 Scores SHALL never exceed WIN_SCORE; no wrap-around.
REQ-026 play_en SHALL be low in the same cycle phase leaves PLAY.

Reset
REQ-027 With rst_n low at a clk edge: phase SPLASH, scores 0, winner 0, play_en 0, ball_reset 0, serve_dir 0, countdown 0, start history 1 (a start held through reset SHALL NOT trigger).
REQ-028 Reset SHALL take priority over every input in any phase, including mid-countdown and the cycle of a goal.

Structure
REQ-029 Phase encodings, winner encodings, and the WIN_SCORE/SERVE_TICKS defaults SHALL live in shared package match_pkg, which the existing game-screen state machine also imports.
REQ-030 The countdown SHALL be one sub-module, serve_timer (load, tick, done), 8-bit down-counter with synchronous active-low reset.

Verification
REQ-031 Reset then start held high 10 cycles -> exactly one SPLASH->SERVE, one ball_reset pulse.
REQ-032 SERVE_TICKS=3, ticks every 4 cycles -> PLAY entered the cycle after the third tick; play_en low until then.
REQ-033 In PLAY, goal_p1 -> p1_score 1, phase SERVE, serve_dir 1, ball_reset pulsed; goal_p2 in the following SERVE has no effect.
REQ-034 Scores 4-4, goal_p1 and goal_p2 in the same cycle -> p1_score 5, p2_score 4, winner 1, phase OVER, no ball_reset.
REQ-035 In OVER, start_rise -> SPLASH with scores 0 and winner 0; goal strobes in SPLASH leave scores 0.
REQ-036 rst_n low during SERVE with countdown 2 -> next cycle SPLASH, all outputs at reset values.
